// File: rtl/alu_flags_datapath.sv
// Accumulator datapath: A/B registers, add/sub ALU, flags, and output register.
// Control word is decoded combinationally; all state updates on the falling edge of clk.
module alu_flags_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ctrl_data,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             bus_conflict,
    output logic             ovf,
    output logic             zf,
    output logic [WIDTH-1:0] out_val,
    output logic             out_strobe,
    output logic [WIDTH-1:0] a_val,
    output logic [WIDTH-1:0] b_val
);

    logic             w_ai;
    logic             w_ao;
    logic             w_eo;
    logic             w_su;
    logic             w_bi;
    logic             w_oi;
    logic             w_fi;
    logic             w_unused_ctrl;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic             r_zf;
    logic             r_strobe;

    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_zero;

    assign w_ai = ctrl_data[9];
    assign w_ao = ctrl_data[8];
    assign w_eo = ctrl_data[7];
    assign w_su = ctrl_data[6];
    assign w_bi = ctrl_data[5];
    assign w_oi = ctrl_data[4];
    assign w_fi = ctrl_data[0];

    // Remaining bits belong to the control unit and memory side of the machine.
    assign w_unused_ctrl = &{ctrl_data[15:10], ctrl_data[3:1], 1'b0};

    // Subtraction as A + ~B + 1, so carry = 1 means no borrow.
    assign w_b_op   = w_su ? ~r_b : r_b;
    assign w_sum    = {1'b0, r_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_su};
    assign w_result = w_sum[WIDTH-1:0];
    assign w_carry  = w_sum[WIDTH];
    assign w_zero   = (w_result == '0);

    always_comb begin
        bus_out = '0;
        if (w_eo) begin
            bus_out = w_result;
        end else if (w_ao) begin
            bus_out = r_a;
        end
    end

    assign bus_oe       = w_ao | w_eo;
    assign bus_conflict = w_ao & w_eo;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_out    <= '0;
            r_ovf    <= 1'b0;
            r_zf     <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            if (w_ai) begin
                r_a <= bus_in;
            end
            if (w_bi) begin
                r_b <= bus_in;
            end
            if (w_oi) begin
                r_out <= bus_in;
            end
            if (w_fi) begin
                r_ovf <= w_carry;
                r_zf  <= w_zero;
            end
            r_strobe <= w_oi;
        end
    end

    assign ovf        = r_ovf;
    assign zf         = r_zf;
    assign out_val    = r_out;
    assign out_strobe = r_strobe;
    assign a_val      = r_a;
    assign b_val      = r_b;

endmodule
